// File: rtl/move_checker_pkg.sv
// Shared board encoding, direction deltas and FSM states for the move checker.
// Addresses follow the row-major layout addr = y*BOARD_DIM + x.
package move_checker_pkg;

  localparam int BOARD_DIM = 8;
  localparam int ADDR_W    = 6;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NW = 3'd7;

  // Index order N, NE, E, SE, S, SW, W, NW; north is decreasing y.
  localparam logic signed [3:0] DX [8] = '{4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1};
  localparam logic signed [3:0] DY [8] = '{-4'sd1, -4'sd1, 4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1};

  typedef enum logic [3:0] {
    S_IDLE, S_C_CUR, S_C_CUR_EV, S_C_REQ, S_C_EVAL, S_F_DIR, S_F_REQ, S_F_EVAL, S_DONE
  } state_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [2:0] x, input logic [2:0] y);
    return ADDR_W'(int'(y) * BOARD_DIM + int'(x));
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/move_checker_if.sv
// Board memory port: registered read (data one cycle after address) plus write strobe.
interface move_checker_if;
  import move_checker_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/move_checker_dir_step.sv
// One step from (x,y) along a direction; shared by the check and flip walks.
module move_checker_dir_step
  import move_checker_pkg::*;
(
  input  logic [2:0]        x_i,
  input  logic [2:0]        y_i,
  input  logic [2:0]        dir_i,
  output logic [2:0]        nx_o,
  output logic [2:0]        ny_o,
  output logic              in_bounds_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic signed [3:0] sx, sy;

  // Stepping past 7 wraps to -8, which the sign test rejects as well.
  assign sx = $signed({1'b0, x_i}) + DX[dir_i];
  assign sy = $signed({1'b0, y_i}) + DY[dir_i];

  assign in_bounds_o = (int'(sx) >= 0) && (int'(sx) < BOARD_DIM) &&
                       (int'(sy) >= 0) && (int'(sy) < BOARD_DIM);
  assign nx_o   = sx[2:0];
  assign ny_o   = sy[2:0];
  assign addr_o = cell_addr(nx_o, ny_o);

endmodule

// File: rtl/move_checker.sv
// Validates a move at the cursor by scanning 8 directions, and flips captured
// pieces on request; four-phase done handshake towards the game control FSM.
module move_checker
  import move_checker_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           check_en_i,
  input  logic           flip_en_i,
  input  logic [2:0]     cursor_x_i,
  input  logic [2:0]     cursor_y_i,
  input  logic           player_i,
  move_checker_if.master bus,
  output logic           done_o,
  output logic           valid_move_o,
  output logic [7:0]     dir_mask_o,
  output logic [5:0]     flip_count_o
);

  state_e      state_q, state_d;
  logic [2:0]  px_q, px_d, py_q, py_d, cx_q, cx_d, cy_q, cy_d, d_q, d_d;
  logic [1:0]  own_q, own_d;
  logic        opp_seen_q, opp_seen_d, is_flip_q, is_flip_d, valid_q, valid_d;
  logic [7:0]  work_q, work_d, dir_mask_q, dir_mask_d;
  logic [5:0]  flip_cnt_q, flip_cnt_d;

  logic [1:0]        opp_col;
  logic [2:0]        nx, ny, low_idx;
  logic              in_b, dir_end;
  logic [ADDR_W-1:0] step_addr;

  move_checker_dir_step u_step (
    .x_i(cx_q), .y_i(cy_q), .dir_i(d_q),
    .nx_o(nx), .ny_o(ny), .in_bounds_o(in_b), .addr_o(step_addr)
  );

  assign opp_col = (own_q == BLACK) ? WHITE : BLACK;
  assign low_idx = lowest_set(work_q);

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    d_d         = d_q;
    own_d       = own_q;
    opp_seen_d  = opp_seen_q;
    is_flip_d   = is_flip_q;
    valid_d     = valid_q;
    work_d      = work_q;
    dir_mask_d  = dir_mask_q;
    flip_cnt_d  = flip_cnt_q;
    dir_end     = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    unique case (state_q)
      S_IDLE: begin
        if (check_en_i || flip_en_i) begin
          px_d      = cursor_x_i;
          py_d      = cursor_y_i;
          own_d     = player_i ? WHITE : BLACK;
          is_flip_d = !check_en_i;
          if (check_en_i) begin
            state_d    = S_C_CUR;
            work_d     = '0;
            dir_mask_d = '0;
            valid_d    = 1'b0;
          end else begin
            state_d    = S_F_DIR;
            work_d     = dir_mask_q;
            flip_cnt_d = '0;
          end
        end
      end
      S_C_CUR: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = cell_addr(px_q, py_q);
        state_d     = S_C_CUR_EV;
      end
      S_C_CUR_EV: begin
        if (bus.rd_data != BLACK && bus.rd_data != WHITE) begin
          state_d    = S_C_REQ;
          d_d        = DIR_N;
          cx_d       = px_q;
          cy_d       = py_q;
          opp_seen_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_C_REQ: begin
        if (!in_b) begin
          dir_end = 1'b1;
        end else begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = step_addr;
          cx_d        = nx;
          cy_d        = ny;
          state_d     = S_C_EVAL;
        end
      end
      S_C_EVAL: begin
        if (bus.rd_data == opp_col) begin
          opp_seen_d = 1'b1;
          state_d    = S_C_REQ;
        end else begin
          if (bus.rd_data == own_q && opp_seen_q) work_d[d_q] = 1'b1;
          dir_end = 1'b1;
        end
      end
      S_F_DIR: begin
        if (work_q == '0) begin
          state_d = S_DONE;
        end else begin
          d_d             = low_idx;
          work_d[low_idx] = 1'b0;
          cx_d            = px_q;
          cy_d            = py_q;
          state_d         = S_F_REQ;
        end
      end
      S_F_REQ: begin
        if (!in_b) begin
          state_d = S_F_DIR;
        end else begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = step_addr;
          cx_d        = nx;
          cy_d        = ny;
          state_d     = S_F_EVAL;
        end
      end
      S_F_EVAL: begin
        if (bus.rd_data == opp_col) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = cell_addr(cx_q, cy_q);
          bus.wr_data = own_q;
          flip_cnt_d  = flip_cnt_q + 6'd1;
          state_d     = S_F_REQ;
        end else begin
          state_d = S_F_DIR;
        end
      end
      S_DONE: begin
        if (is_flip_q ? !flip_en_i : !check_en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (dir_end) begin
      if (d_q == DIR_NW) begin
        state_d = S_DONE;
      end else begin
        d_d        = d_q + 3'd1;
        cx_d       = px_q;
        cy_d       = py_q;
        opp_seen_d = 1'b0;
        state_d    = S_C_REQ;
      end
    end

    // Check results become visible only once the whole scan has finished.
    if (!is_flip_q && state_q != S_IDLE && state_q != S_DONE && state_d == S_DONE) begin
      dir_mask_d = work_d;
      valid_d    = |work_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      px_q       <= '0;
      py_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      d_q        <= '0;
      own_q      <= '0;
      opp_seen_q <= 1'b0;
      is_flip_q  <= 1'b0;
      valid_q    <= 1'b0;
      work_q     <= '0;
      dir_mask_q <= '0;
      flip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      d_q        <= d_d;
      own_q      <= own_d;
      opp_seen_q <= opp_seen_d;
      is_flip_q  <= is_flip_d;
      valid_q    <= valid_d;
      work_q     <= work_d;
      dir_mask_q <= dir_mask_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end

  assign done_o       = (state_q == S_DONE);
  assign valid_move_o = valid_q;
  assign dir_mask_o   = dir_mask_q;
  assign flip_count_o = flip_cnt_q;

endmodule

// File: tb/tb_move_checker.sv
// Self-checking bench: board memory model plus a direction-walking reference
// that predicts reads, writes, dir_mask and flip_count for each operation.
module tb_move_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       check_en, flip_en;
  logic [2:0] cx, cy;
  logic       player;
  logic       done, valid;
  logic [7:0] dir_mask;
  logic [5:0] flip_count;

  move_checker_if bus ();

  move_checker dut (
    .clk(clk), .reset(reset),
    .check_en_i(check_en), .flip_en_i(flip_en),
    .cursor_x_i(cx), .cursor_y_i(cy), .player_i(player),
    .bus(bus),
    .done_o(done), .valid_move_o(valid),
    .dir_mask_o(dir_mask), .flip_count_o(flip_count)
  );

  always #5 clk = ~clk;

  logic [1:0] board [64];
  logic [1:0] init_board [64];
  bit         load_now = 1'b0;

  always @(posedge clk) begin
    bus.rd_data <= board[bus.rd_addr];
    if (load_now) board <= init_board;
    else if (bus.wr_en) board[bus.wr_addr] <= bus.wr_data;
  end

  int DXM [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DYM [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  int         n_cmp = 0, n_fail = 0;
  int         exp_rd[$], exp_wr[$];
  logic [7:0] m_mask;
  int         m_flips;
  bit         op_flip, track;
  logic [1:0] op_own;
  int         cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit inb(input int x, input int y);
    return x >= 0 && x < 8 && y >= 0 && y < 8;
  endfunction

  // Reference: walk each direction over the board array directly.
  function automatic void model_check(input int px, input int py, input bit pl);
    int own, opp, x, y, n, v;
    own = pl ? 2 : 1;
    opp = pl ? 1 : 2;
    exp_rd.delete();
    exp_wr.delete();
    m_mask = '0;
    exp_rd.push_back(py * 8 + px);
    v = int'(board[py * 8 + px]);
    if (v == 1 || v == 2) return;
    for (int d = 0; d < 8; d++) begin
      x = px; y = py; n = 0;
      forever begin
        x += DXM[d]; y += DYM[d];
        if (!inb(x, y)) break;
        exp_rd.push_back(y * 8 + x);
        v = int'(board[y * 8 + x]);
        if (v == opp) n++;
        else begin
          if (v == own && n > 0) m_mask[d] = 1'b1;
          break;
        end
      end
    end
  endfunction

  function automatic void model_flip(input int px, input int py, input bit pl);
    int opp, x, y;
    opp = pl ? 1 : 2;
    exp_rd.delete();
    exp_wr.delete();
    m_flips = 0;
    for (int d = 0; d < 8; d++) begin
      if (m_mask[d]) begin
        x = px; y = py;
        forever begin
          x += DXM[d]; y += DYM[d];
          if (!inb(x, y)) break;
          exp_rd.push_back(y * 8 + x);
          if (int'(board[y * 8 + x]) == opp) begin
            exp_wr.push_back(y * 8 + x);
            m_flips++;
          end else break;
        end
      end
    end
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!reset && track) begin
        if (bus.rd_en) begin
          chk("rd_expected_avail", 32'(exp_rd.size() > 0), 1);
          if (exp_rd.size() > 0) chk("rd_addr", 32'(bus.rd_addr), exp_rd.pop_front());
        end
        if (bus.wr_en) begin
          chk("wr_only_in_flip", 32'(op_flip), 1);
          chk("wr_data_own", 32'(bus.wr_data), 32'(op_own));
          chk("wr_expected_avail", 32'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) chk("wr_addr", 32'(bus.wr_addr), exp_wr.pop_front());
        end
      end
    end
  endtask

  task automatic load_board();
    load_now = 1'b1;
    @(posedge clk); #1;
    load_now = 1'b0;
  endtask

  task automatic clear_init();
    for (int i = 0; i < 64; i++) init_board[i] = 2'b00;
  endtask

  task automatic opening_init();
    clear_init();
    init_board[27] = 2'b10; init_board[36] = 2'b10;
    init_board[28] = 2'b01; init_board[35] = 2'b01;
  endtask

  task automatic run_op(input bit flip, input bit both, input int px, input int py,
                        input bit pl, input bit scramble, output int cycles);
    if (flip) model_flip(px, py, pl); else model_check(px, py, pl);
    op_flip = flip;
    op_own  = pl ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    cx = px[2:0]; cy = py[2:0]; player = pl;
    check_en = !flip || both;
    flip_en  = flip || both;
    cycles = 0;
    if (scramble) begin
      @(negedge clk); cycles++;
      @(posedge clk); #1;
      cx = 3'($urandom_range(0, 7)); cy = 3'($urandom_range(0, 7)); player = 1'($urandom_range(0, 1));
    end
    do begin
      @(negedge clk); cycles++;
    end while (!done && cycles < 200);
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", cycles);
    end
    if (flip) chk("flip_count", 32'(flip_count), m_flips);
    else      chk("valid_move", 32'(valid), 32'(|m_mask));
    chk("dir_mask", 32'(dir_mask), 32'(m_mask));
    repeat (2) begin
      @(negedge clk); chk("done_held", 32'(done), 1);
    end
    @(posedge clk); #1;
    check_en = 1'b0; flip_en = 1'b0;
    @(negedge clk); chk("done_before_drop", 32'(done), 1);
    @(negedge clk); chk("done_dropped", 32'(done), 0);
    chk("reads_left", exp_rd.size(), 0);
    chk("writes_left", exp_wr.size(), 0);
  endtask

  task automatic reset_mid(input bit flip, input int px, input int py, input bit pl, input int wait_cyc);
    track = 1'b0;
    @(posedge clk); #1;
    cx = px[2:0]; cy = py[2:0]; player = pl;
    check_en = !flip; flip_en = flip;
    repeat (wait_cyc) @(posedge clk);
    #1;
    reset = 1'b1; check_en = 1'b0; flip_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_valid", 32'(valid), 0);
    chk("rst_mid_dir_mask", 32'(dir_mask), 0);
    chk("rst_mid_flip_count", 32'(flip_count), 0);
    chk("rst_mid_rd_en", 32'(bus.rd_en), 0);
    chk("rst_mid_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_mid_wr_en", 32'(bus.wr_en), 0);
    exp_rd.delete(); exp_wr.delete();
    track = 1'b1;
  endtask

  initial begin
    int px, py;
    bit pl;
    reset = 1'b1; check_en = 1'b0; flip_en = 1'b0;
    cx = '0; cy = '0; player = 1'b0; track = 1'b0; op_flip = 1'b0; op_own = 2'b01;
    opening_init();
    load_board();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_dir_mask", 32'(dir_mask), 0);
    chk("rst_flip_count", 32'(flip_count), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, 0);
    fork monitor_loop(); join_none
    track = 1'b1;

    // Opening position, black to move at (3,2): capture southwards only.
    run_op(1'b0, 1'b0, 3, 2, 1'b0, 1'b0, cyc);
    chk("pin_open_mask", 32'(m_mask), 32'h10);
    chk("open_dir_mask_lit", 32'(dir_mask), 32'h10);
    chk("open_valid_lit", 32'(valid), 1);
    run_op(1'b1, 1'b0, 3, 2, 1'b0, 1'b0, cyc);
    chk("pin_open_flips", m_flips, 1);
    chk("open_flip_count_lit", 32'(flip_count), 1);
    chk("open_board27", 32'(board[27]), 1);

    // Corner cursor: reads the cursor then cells 1, 9, 8 in direction order.
    opening_init();
    load_board();
    model_check(0, 0, 1'b0);
    chk("pin_corner_nreads", exp_rd.size(), 4);
    if (exp_rd.size() == 4)
      chk("pin_corner_reads", {8'(exp_rd[0]), 8'(exp_rd[1]), 8'(exp_rd[2]), 8'(exp_rd[3])}, 32'h00010908);
    run_op(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, cyc);
    chk("corner_valid", 32'(valid), 0);

    // Occupied cursor: single read, quick completion.
    model_check(3, 3, 1'b0);
    chk("pin_occupied_nreads", exp_rd.size(), 1);
    run_op(1'b0, 1'b0, 3, 3, 1'b0, 1'b0, cyc);
    chk("occupied_latency_le4", 32'(cyc <= 4), 1);
    chk("occupied_valid", 32'(valid), 0);

    // Captures N (one piece) and E (two pieces) from (2,4).
    clear_init();
    init_board[26] = 2'b10; init_board[18] = 2'b01;
    init_board[35] = 2'b10; init_board[36] = 2'b10; init_board[37] = 2'b01;
    load_board();
    run_op(1'b0, 1'b0, 2, 4, 1'b0, 1'b0, cyc);
    chk("pin_ne_mask", 32'(m_mask), 32'h05);
    run_op(1'b1, 1'b0, 2, 4, 1'b0, 1'b0, cyc);
    chk("pin_ne_flips", m_flips, 3);
    chk("ne_flipped_cells", {board[26], board[35], board[36]}, 6'b010101);

    // Both enables: check wins, flip_count from the previous flip is untouched.
    opening_init();
    load_board();
    run_op(1'b0, 1'b1, 3, 2, 1'b0, 1'b0, cyc);
    chk("both_flip_count_kept", 32'(flip_count), 3);

    // Reset mid-scan, then mid-flip (dir_mask non-zero beforehand).
    reset_mid(1'b0, 3, 2, 1'b0, 5);
    run_op(1'b0, 1'b0, 3, 2, 1'b0, 1'b0, cyc);
    chk("after_rst_mask_lit", 32'(dir_mask), 32'h10);
    reset_mid(1'b1, 3, 2, 1'b0, 1);
    opening_init();
    load_board();
    run_op(1'b0, 1'b0, 3, 2, 1'b0, 1'b0, cyc);

    // Random boards; inputs are scrambled after start to confirm latching.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 64; i++)
        init_board[i] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      px = $urandom_range(0, 7);
      py = $urandom_range(0, 7);
      pl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) init_board[py * 8 + px] = 2'b00;
      load_board();
      run_op(1'b0, 1'b0, px, py, pl, 1'b1, cyc);
      run_op(1'b1, 1'b0, px, py, pl, 1'b1, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
